fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//  Program counter and IF/ID pipeline register. Drives the byte address into fetch instruction memory.
//  Captures the returned word into the IF/ID latch for decode, with its PC and a valid bit.
//  Handles boot from start_addr, stall, taken branch (MIPS delay slot honoured) and exception vectoring into the IVT.
// PARAMETERS
//  IVT_BASE_ADDR  32'h0000_0180  byte address of IVT entry 0; vector = IVT_BASE_ADDR + {exc_cause,2'b00}
//  CAUSE_W        5              width of exc_cause
// PORTS
//  clock           in   1        single clock; all state updates on posedge
//  reset_n         in   1        asynchronous, active-low reset
//  start_addr      in   32       boot PC from fetch memory (word aligned)
//  mem_instruction in   32       combinational instruction word for current pc
//  stall           in   1        decode back-pressure; hold pc and IF/ID
//  branch_taken    in   1        decode-resolved taken branch/jump
//  branch_target   in   32       target byte address
//  exc_req         in   1        exception request (one-cycle pulse)
//  exc_cause       in   CAUSE_W  IVT entry index
//  pc              out  32       fetch address to memory readAddress
//  if_instr        out  32       IF/ID instruction
//  if_pc           out  32       IF/ID instruction address
//  if_valid        out  1        IF/ID holds a real instruction
//  epc             out  32       address of instruction in IF/ID when exception taken
//  misalign_fault  out  1        one-cycle pulse: branch_target[1:0]!=0 (target masked)
// BEHAVIOUR
//  Reset (async, reset_n=0): pc=0, if_instr=0 (NOP), if_pc=0, if_valid=0, epc=0, misalign_fault=0, state=BOOT.
//  States: BOOT -> RUN only. Reset mid-operation always returns to BOOT; IF/ID is cleared.
//  BOOT: first posedge after reset release: pc<=start_addr & ~3, if_valid<=0, state<=RUN. All inputs ignored.
//  RUN, per posedge, priority exc_req > stall > branch_taken > sequential:
//   exc_req: epc<=if_pc; pc<=IVT_BASE_ADDR+{exc_cause,2'b00}; if_valid<=0; if_instr<=0. Overrides stall.
//   stall (no exc): pc, if_instr, if_pc, if_valid held. A branch_taken asserted with stall is ignored;
//     decode re-asserts it after the stall.
//   branch_taken: IF/ID captures current fetch (delay slot): if_instr<=mem_instruction, if_pc<=pc, if_valid<=1;
//     pc<=branch_target & ~3; misalign_fault<=|branch_target[1:0].
//   sequential: if_instr<=mem_instruction, if_pc<=pc, if_valid<=1, pc<=pc+4.
//  misalign_fault: asserted 1 cycle after the faulting branch; cleared by any other cycle.
//  pc arithmetic: 32-bit unsigned modulo; 32'hFFFF_FFFC+4 wraps to 0. No carry out.
//  Latency: instruction at pc appears on if_instr one posedge later. Redirect is visible on pc the next cycle.
//  Delay-slot reporting: an exception flushes IF/ID, so epc names the flushed instruction for restart.
// CONFIGURATION
//  FETCH_TRACE_EN defined: on every posedge that sets if_valid<=1, $display($time, pc, mem_instruction).
//    Also print on each redirect: "BRANCH"/"EXC" with the new pc.
//  FETCH_TRACE_EN undefined: no $display; identical cycle behaviour.
// STRUCTURE
//  mips.h (shared): `FETCH_BOOT/`FETCH_RUN state encodings, `NOP_INSTR (32'h0), `IVT_BASE_ADDR default, `PC_INCR (4).
//  Sub-module fetch_if_id_reg: if_instr/if_pc/if_valid with load, hold and flush controls; async reset_n.
//  Top: state register, pc next-state mux, epc and misalign_fault registers.
// TESTING
//  Boot: start_addr=32'h0040_0000, release reset_n -> pc=0x0040_0000 after 1 posedge, if_valid=0.
//    Next posedge: if_pc=0x0040_0000, if_valid=1.
//  Sequential + stall: 3 fetches, then stall=1 for 2 cycles -> pc and if_* frozen.
//    Release stall -> pc resumes +4, no fetch lost or duplicated.
//  Branch: pc=0x0040_0008, branch_taken=1, target=0x0040_0100 -> if_pc=0x0040_0008 (delay slot) valid.
//    Next pc=0x0040_0100. Target 0x0040_0102 -> pc=0x0040_0100, misalign_fault=1 for 1 cycle.
//  Exception over stall: if_pc=0x0040_0010, stall=1, exc_req=1, exc_cause=3 -> pc=0x0000_018C, epc=0x0040_0010, if_valid=0.
//  Wrap + async reset: pc=0xFFFF_FFFC sequential -> pc=0.
//    Drop reset_n mid-cycle -> all outputs 0 immediately, state BOOT, re-boot from start_addr.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch-stage definitions: FSM state encodings, NOP word, IVT base default, PC step.
package fetch_pc_unit_pkg;

  typedef enum logic {
    FETCH_BOOT = 1'b0,
    FETCH_RUN  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] IVT_BASE_DEFAULT = 32'h0000_0180;
  localparam logic [31:0] PC_INCR          = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if_id_reg.sv
// IF/ID pipeline latch: instruction, its address and a valid bit; 1-cycle capture.
// Flush wins over load; with neither asserted the contents hold (stall).
module fetch_if_id_reg
  import fetch_pc_unit_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_valid
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    if (flush) begin
      // if_pc is kept so the flushed slot's address stays observable
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = instr_in;
      ipc_d   = pc_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instr_q <= NOP_INSTR;
      ipc_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
    end
  end

  assign if_instr = instr_q;
  assign if_pc    = ipc_q;
  assign if_valid = valid_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter, boot/run FSM, redirect (branch with delay slot, IVT exception) and IF/ID latch.
// Optional FETCH_TRACE_EN macro adds a simulation trace of fetches and redirects.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] IVT_BASE_ADDR = IVT_BASE_DEFAULT,
  parameter int          CAUSE_W       = 5
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [31:0]        start_addr,
  input  logic [31:0]        mem_instruction,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  input  logic               exc_req,
  input  logic [CAUSE_W-1:0] exc_cause,
  output logic [31:0]        pc,
  output logic [31:0]        if_instr,
  output logic [31:0]        if_pc,
  output logic               if_valid,
  output logic [31:0]        epc,
  output logic               misalign_fault
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  epc_q, epc_d;
  logic         mis_q, mis_d;
  logic         ifid_load, ifid_flush;
  logic [31:0]  vec_addr;

  assign vec_addr = IVT_BASE_ADDR + {{(30-CAUSE_W){1'b0}}, exc_cause, 2'b00};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    mis_d      = 1'b0;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    if (state_q == FETCH_BOOT) begin
      pc_d       = word_align(start_addr);
      ifid_flush = 1'b1;
      state_d    = FETCH_RUN;
    end else if (exc_req) begin
      epc_d      = if_pc;
      pc_d       = vec_addr;
      ifid_flush = 1'b1;
    end else if (!stall) begin
      // a taken branch still captures the current fetch: that is the delay slot
      ifid_load = 1'b1;
      if (branch_taken) begin
        pc_d  = word_align(branch_target);
        mis_d = |branch_target[1:0];
      end else begin
        pc_d = pc_q + PC_INCR;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH_BOOT;
      pc_q    <= 32'h0;
      epc_q   <= 32'h0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      mis_q   <= mis_d;
    end
  end

  fetch_if_id_reg u_if_id (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (ifid_load),
    .flush    (ifid_flush),
    .instr_in (mem_instruction),
    .pc_in    (pc_q),
    .if_instr (if_instr),
    .if_pc    (if_pc),
    .if_valid (if_valid)
  );

  assign pc             = pc_q;
  assign epc            = epc_q;
  assign misalign_fault = mis_q;

`ifdef FETCH_TRACE_EN
  always @(posedge clock) begin
    if (reset_n && state_q == FETCH_RUN) begin
      if (exc_req)
        $display("%0t EXC pc=%h", $time, pc_d);
      else if (!stall) begin
        $display("%0t FETCH pc=%h instr=%h", $time, pc_q, mem_instruction);
        if (branch_taken)
          $display("%0t BRANCH pc=%h", $time, pc_d);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed vector table, reset corner sequences, randomized run vs model.
module tb_fetch_pc_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] start_addr, mem_instruction, branch_target;
  logic        stall, branch_taken, exc_req;
  logic [4:0]  exc_cause;
  logic [31:0] pc, if_instr, if_pc, epc;
  logic        if_valid, misalign_fault;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign mem_instruction = mem_word(pc);

  fetch_pc_unit dut (
    .clock(clock), .reset_n(reset_n), .start_addr(start_addr),
    .mem_instruction(mem_instruction), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .exc_req(exc_req), .exc_cause(exc_cause),
    .pc(pc), .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
    .epc(epc), .misalign_fault(misalign_fault)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic b, input logic [31:0] t,
                       input logic e, input logic [4:0] c);
    stall = s; branch_taken = b; branch_target = t; exc_req = e; exc_cause = c;
  endtask

  typedef struct {
    logic        stall, br;
    logic [31:0] tgt;
    logic        exc;
    logic [4:0]  cause;
    logic [31:0] pc, if_pc;
    logic        vld, mis;
    logic [31:0] epc;
    logic        chk_ifpc;
  } vec_t;

  vec_t vt[16];

  function automatic vec_t v(input logic s, input logic b, input logic [31:0] t,
                             input logic e, input logic [4:0] c, input logic [31:0] p,
                             input logic [31:0] ip, input logic vl, input logic m,
                             input logic [31:0] ep, input logic ci);
    vec_t r;
    r.stall = s; r.br = b; r.tgt = t; r.exc = e; r.cause = c; r.pc = p; r.if_pc = ip;
    r.vld = vl; r.mis = m; r.epc = ep; r.chk_ifpc = ci;
    return r;
  endfunction

  // behavioural model state
  bit          m_run;
  logic [31:0] m_pc, m_instr, m_ifpc, m_epc;
  logic        m_valid, m_mis;

  task automatic model_reset();
    m_run = 0; m_pc = 0; m_instr = 0; m_ifpc = 0; m_epc = 0; m_valid = 0; m_mis = 0;
  endtask

  task automatic model_step();
    if (!m_run) begin
      m_pc = start_addr & ~32'h3; m_valid = 0; m_instr = 0; m_mis = 0; m_run = 1;
    end else if (exc_req) begin
      m_epc = m_ifpc; m_pc = 32'h180 + 32'(exc_cause) * 4;
      m_valid = 0; m_instr = 0; m_mis = 0;
    end else if (stall) begin
      m_mis = 0;
    end else begin
      m_instr = mem_word(m_pc); m_ifpc = m_pc; m_valid = 1;
      if (branch_taken) begin
        m_pc = branch_target & ~32'h3; m_mis = (branch_target % 4) != 0;
      end else begin
        m_pc = m_pc + 32'd4; m_mis = 0;
      end
    end
  endtask

  initial begin
    vt[0]  = v(0,0,0,           0,0, 32'h0040_0004, 32'h0040_0000, 1,0, 0, 1);
    vt[1]  = v(0,0,0,           0,0, 32'h0040_0008, 32'h0040_0004, 1,0, 0, 1);
    vt[2]  = v(1,0,0,           0,0, 32'h0040_0008, 32'h0040_0004, 1,0, 0, 1);
    vt[3]  = v(1,1,32'h0000_5000,0,0,32'h0040_0008, 32'h0040_0004, 1,0, 0, 1);
    vt[4]  = v(0,1,32'h0040_0100,0,0,32'h0040_0100, 32'h0040_0008, 1,0, 0, 1);
    vt[5]  = v(0,0,0,           0,0, 32'h0040_0104, 32'h0040_0100, 1,0, 0, 1);
    vt[6]  = v(0,1,32'h0040_0102,0,0,32'h0040_0100, 32'h0040_0104, 1,1, 0, 1);
    vt[7]  = v(0,0,0,           0,0, 32'h0040_0104, 32'h0040_0100, 1,0, 0, 1);
    vt[8]  = v(0,0,0,           0,0, 32'h0040_0108, 32'h0040_0104, 1,0, 0, 1);
    vt[9]  = v(0,0,0,           0,0, 32'h0040_010C, 32'h0040_0108, 1,0, 0, 1);
    vt[10] = v(0,0,0,           0,0, 32'h0040_0110, 32'h0040_010C, 1,0, 0, 1);
    vt[11] = v(0,0,0,           0,0, 32'h0040_0114, 32'h0040_0110, 1,0, 0, 1);
    vt[12] = v(1,1,32'h0000_2000,1,3,32'h0000_018C, 32'h0, 0,0, 32'h0040_0110, 0);
    vt[13] = v(0,0,0,           0,0, 32'h0000_0190, 32'h0000_018C, 1,0, 32'h0040_0110, 1);
    vt[14] = v(0,1,32'hFFFF_FFFC,0,0,32'hFFFF_FFFC, 32'h0000_0190, 1,0, 32'h0040_0110, 1);
    vt[15] = v(0,0,0,           0,0, 32'h0000_0000, 32'hFFFF_FFFC, 1,0, 32'h0040_0110, 1);

    reset_n = 0; start_addr = 32'h0040_0000;
    drive(0, 0, 0, 0, 0);
    #12;
    chk("reset_pc", pc, 0);
    chk("reset_if_instr", if_instr, 0);
    chk("reset_if_valid", {31'b0, if_valid}, 0);
    chk("reset_mis", {31'b0, misalign_fault}, 0);

    // boot ignores inputs
    drive(1, 1, 32'h0000_7777, 1, 5'd9);
    @(negedge clock) reset_n = 1;
    @(posedge clock); #1;
    chk("boot_pc", pc, 32'h0040_0000);
    chk("boot_if_valid", {31'b0, if_valid}, 0);
    chk("boot_epc", epc, 0);

    for (int i = 0; i < 16; i++) begin
      drive(vt[i].stall, vt[i].br, vt[i].tgt, vt[i].exc, vt[i].cause);
      @(posedge clock); #1;
      chk($sformatf("vec%0d_pc", i), pc, vt[i].pc);
      chk($sformatf("vec%0d_valid", i), {31'b0, if_valid}, {31'b0, vt[i].vld});
      chk($sformatf("vec%0d_mis", i), {31'b0, misalign_fault}, {31'b0, vt[i].mis});
      chk($sformatf("vec%0d_epc", i), epc, vt[i].epc);
      chk($sformatf("vec%0d_instr", i), if_instr, vt[i].vld ? mem_word(vt[i].if_pc) : 32'h0);
      if (vt[i].chk_ifpc) chk($sformatf("vec%0d_if_pc", i), if_pc, vt[i].if_pc);
    end

    // asynchronous reset mid-cycle, then re-boot from a misaligned start address
    #2 reset_n = 0;
    #1;
    chk("areset_pc", pc, 0);
    chk("areset_if_pc", if_pc, 0);
    chk("areset_if_valid", {31'b0, if_valid}, 0);
    chk("areset_epc", epc, 0);
    start_addr = 32'h0000_1003;
    drive(0, 0, 0, 0, 0);
    @(negedge clock) reset_n = 1;
    @(posedge clock); #1;
    chk("reboot_pc", pc, 32'h0000_1000);
    chk("reboot_if_valid", {31'b0, if_valid}, 0);
    @(posedge clock); #1;
    chk("reboot_if_pc", if_pc, 32'h0000_1000);
    chk("reboot_if_valid2", {31'b0, if_valid}, 1);
    chk("reboot_pc2", pc, 32'h0000_1004);

    // randomized run against the model
    @(negedge clock) reset_n = 0;
    model_reset();
    start_addr = $urandom;
    @(negedge clock) reset_n = 1;
    #1;
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), $urandom,
            ($urandom_range(0, 15) == 0), 5'($urandom));
      model_step();
      @(posedge clock); #1;
      chk("rnd_pc", pc, m_pc);
      chk("rnd_valid", {31'b0, if_valid}, {31'b0, m_valid});
      chk("rnd_instr", if_instr, m_instr);
      chk("rnd_mis", {31'b0, misalign_fault}, {31'b0, m_mis});
      chk("rnd_epc", epc, m_epc);
      if (m_valid) chk("rnd_if_pc", if_pc, m_ifpc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
